pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor of the team's single-bit half adder.
- Adds or subtracts two WIDTH-bit operands with a carry chain split into SEG_W-bit registered segments, one segment per stage.
- Valid/ready on input and output; one operation per cycle in steady state.
- Sits between operand producers and downstream consumers in datapath tests and as the reusable arithmetic primitive of the utility library.

Parameters:
- WIDTH, 8: operand/result width in bits.
- SEG_W, 4: bits resolved per pipeline stage. WIDTH % SEG_W != 0 causes an elaboration $fatal.
- NUM_SEG, WIDTH/SEG_W: localparam, not overridable; equals pipeline depth/latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block accepts operand this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; used only when sub=0.
- sub  in  1  0 = a+b+cin, 1 = a-b (cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out; in subtract mode 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - rst high clears all stage valids, sum, cout and ovf to 0 immediately; it is asynchronous.
  - in_ready = 1 while no result is stalled.
  - Assertion mid-operation discards every in-flight op; nothing is emitted after release.
- Handshake:
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - stall = out_valid & !out_ready; in_ready = !stall. in_ready is combinational from out_ready.
  - On stall the whole pipeline freezes, including bubbles; there is no bubble collapsing.
- Latency: exactly NUM_SEG cycles from input transfer to out_valid when unstalled; NUM_SEG=1 gives 1-cycle latency.
- Throughput: 1 op/cycle. Results leave in acceptance order, never lost or duplicated.
- Operand preparation at acceptance:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (0..NUM_SEG-1):
  - Registers segment k of the sum from a[k] + b_eff[k] + carry from stage k-1 (stage 0 uses c0).
  - Forwards the carry to stage k+1.
- Skew and deskew:
  - Unconsumed upper operand segments are carried in skew registers alongside the op.
  - Completed lower sum segments are delayed so all segments of one op appear together.
- Final stage:
  - cout = carry out of the MSB segment.
  - ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]). The MSBs of a and b_eff are carried to the last stage for this.
- Outputs:
  - sum/cout/ovf hold their value while out_valid & !out_ready.
  - When out_valid = 0 they keep their last value; the bench must not check them.
- Simultaneous events:
  - Input and output transfer in the same cycle is legal: the pipeline advances.
  - Stall while in_valid is high blocks acceptance; the operand must be held by the producer.
- Wrap-around: modulo 2^WIDTH result; carries and overflow are reported, never saturated.

Decomposition:
- Package adder_pkg holds:
  - typedef enum logic {OP_ADD, OP_SUB} op_e, mapped to the sub port.
  - Function seg_count(width, seg_w).
  - Default parameter constants.
- Sub-module adder_seg: SEG_W-bit registered slice with inputs a, b, cin and enable; outputs registered sum and carry. It is instantiated NUM_SEG times via generate.
- Skew/deskew registers and valid pipeline live in the top level.

Test Plan (WIDTH=8, SEG_W=4, latency 2):
- Reset: hold rst high 2 cycles, then pulse it with no input -> out_valid=0, sum=0x00, cout=0, ovf=0, in_ready=1.
- Cross-segment carry:
  - 0x0F + 0x01, cin=0 -> 2 cycles later sum=0x10, cout=0, ovf=0.
  - 0xFF + 0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
- Signed overflow: 0x7F + 0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract:
  - 0x05 - 0x07 -> sum=0xFE, cout=0, ovf=0.
  - 0x80 - 0x01 -> sum=0x7F, cout=1, ovf=1.
  - 0x07 - 0x07 with cin=1 -> sum=0x00, cout=1 (cin ignored).
- Backpressure: stream 6 back-to-back adds (i + 0x10, i = 0..5) with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, 6 results 0x10..0x15 in order, no gaps beyond the stall, no duplicates.
- Reset mid-flight: accept 2 ops, assert rst asynchronously between clock edges -> out_valid drops immediately; after release no result appears and the next op returns in exactly 2 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types, defaults and helpers for the segmented pipelined adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_SEG_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Pipeline depth: one registered segment per stage.
    function automatic int unsigned seg_count(input int unsigned width, input int unsigned seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result valid-ready bundle of the pipelined adder.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = adder_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_seg.sv
// One registered SEG_W-bit slice of the carry chain.
module adder_seg #(
    parameter int unsigned SEG_W = adder_pkg::DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             c_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             c_o
);

    localparam int unsigned RW = SEG_W + 1;

    logic [RW-1:0]    res_d;
    logic [SEG_W-1:0] sum_q;
    logic             c_q;

    assign res_d = RW'(a_i) + RW'(b_i) + RW'(c_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            c_q   <= 1'b0;
        end else if (en_i) begin
            sum_q <= res_d[SEG_W-1:0];
            c_q   <= res_d[SEG_W];
        end
    end

    assign sum_o = sum_q;
    assign c_o   = c_q;

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract with the carry chain split into registered segments; the whole
// pipeline freezes while a result is stalled at the output.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);

    localparam int unsigned NUM_SEG = seg_count(WIDTH, SEG_W);

    if ((WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $fatal(1, "pipelined_adder: WIDTH must be a multiple of SEG_W");
    end

    op_e              op;
    logic             stall_c;
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [NUM_SEG-1:0] vld_q;
    logic             am_q;
    logic             bm_q;

    assign stall_c      = vld_q[NUM_SEG-1] & ~bus.out_ready;
    assign adv          = ~stall_c;
    assign bus.in_ready = adv;

    // Subtraction is a + ~b + 1; cin only matters when adding.
    assign op    = op_e'(bus.sub);
    assign b_eff = (op == OP_SUB) ? ~bus.b : bus.b;
    assign c0    = (op == OP_SUB) ? 1'b1 : bus.cin;

    if (NUM_SEG == 1) begin : g_vld1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q <= bus.in_valid;
            end
        end
    end else begin : g_vldn
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q <= {vld_q[NUM_SEG-2:0], bus.in_valid};
            end
        end
    end

    for (genvar s = 0; s < NUM_SEG; s++) begin : g_st
        localparam int unsigned RW = (NUM_SEG - s) * SEG_W;

        // Operand segments s..NUM_SEG-1 of the op currently at this stage.
        logic [RW-1:0]            a_rest;
        logic [RW-1:0]            b_rest;
        logic                     c_in;
        logic [SEG_W-1:0]         seg_sum;
        logic                     seg_c;
        logic [(s+1)*SEG_W-1:0]   done;

        if (s == 0) begin : g_src
            assign a_rest = bus.a;
            assign b_rest = b_eff;
            assign c_in   = c0;
        end else begin : g_src
            assign a_rest = g_st[s-1].g_skew.a_hi_q;
            assign b_rest = g_st[s-1].g_skew.b_hi_q;
            assign c_in   = g_st[s-1].seg_c;
        end

        adder_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk   (clk),
            .rst   (rst),
            .en_i  (adv),
            .a_i   (a_rest[SEG_W-1:0]),
            .b_i   (b_rest[SEG_W-1:0]),
            .c_i   (c_in),
            .sum_o (seg_sum),
            .c_o   (seg_c)
        );

        if (s < NUM_SEG - 1) begin : g_skew
            logic [RW-SEG_W-1:0] a_hi_q;
            logic [RW-SEG_W-1:0] b_hi_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (adv) begin
                    a_hi_q <= a_rest[RW-1:SEG_W];
                    b_hi_q <= b_rest[RW-1:SEG_W];
                end
            end
        end else begin : g_msb
            // Operand MSBs travel with the top segment for overflow detection.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    am_q <= 1'b0;
                    bm_q <= 1'b0;
                end else if (adv) begin
                    am_q <= a_rest[RW-1];
                    bm_q <= b_rest[RW-1];
                end
            end
        end

        if (s == 0) begin : g_done
            assign done = seg_sum;
        end else begin : g_done
            // Lower sum segments delayed to line up with this stage's segment.
            logic [s*SEG_W-1:0] lo_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lo_q <= '0;
                end else if (adv) begin
                    lo_q <= g_st[s-1].done;
                end
            end

            assign done = {seg_sum, lo_q};
        end
    end

    assign bus.out_valid = vld_q[NUM_SEG-1];
    assign bus.sum       = g_st[NUM_SEG-1].done;
    assign bus.cout      = g_st[NUM_SEG-1].seg_c;
    assign bus.ovf       = (am_q == bm_q) & (g_st[NUM_SEG-1].seg_sum[SEG_W-1] != am_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, SEG_W=4): directed corner
// cases, backpressure, reset mid-flight and a randomized stream.
module tb_pipelined_adder;

    localparam int unsigned W       = 8;
    localparam int          LATENCY = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(
        .WIDTH (W),
        .SEG_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
        int         stl;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   stalls   = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   flushed  = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int res;
        int sres;
        if (!sub) begin
            res    = ua + ub + int'(cin);
            sres   = sa + sb + int'(cin);
            e.cout = (res > 255);
        end else begin
            res    = ua - ub;
            sres   = sa - sb;
            e.cout = (ua >= ub);
        end
        e.sum = res[7:0];
        e.ovf = (sres > 127) || (sres < -128);
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin : recorder
        exp_t e;
        if (!rst && bus.in_valid && bus.in_ready) begin
            e     = model(bus.a, bus.b, bus.cin, bus.sub);
            e.acc = cyc;
            e.stl = stalls;
            exp_q.push_back(e);
            pushed++;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum %0h with nothing outstanding", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    chk("sum", 32'(bus.sum), 32'(e.sum));
                    chk("cout", 32'(bus.cout), 32'(e.cout));
                    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                    chk("latency", 32'(cyc - e.acc - (stalls - e.stl)), 32'(LATENCY));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one operand and hold it until the adder takes it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        bit ok = 1'b0;
        int n  = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: operand %0h/%0h not taken in %0d cycles", a, b, n);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'(0));
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    logic [7:0] dir_a   [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h07};
    logic [7:0] dir_b   [6] = '{8'h01, 8'h00, 8'h01, 8'h07, 8'h01, 8'h07};
    logic       dir_cin [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       dir_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_sum", 32'(bus.sum), 32'(0));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("pulse_out_valid", 32'(bus.out_valid), 32'(0));
        chk("pulse_sum", 32'(bus.sum), 32'(0));
        chk("pulse_cout", 32'(bus.cout), 32'(0));
        chk("pulse_ovf", 32'(bus.ovf), 32'(0));
        chk("pulse_in_ready", 32'(bus.in_ready), 32'(1));
        tick();

        // Carry across the segment boundary, overflow and subtract corners.
        for (int i = 0; i < 6; i++) begin
            send(dir_a[i], dir_b[i], dir_cin[i], dir_sub[i]);
            if (i % 2 == 1) tick();
        end
        drain();

        // Back-to-back stream with a three-cycle consumer stall mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) send(8'(i), 8'h10, 1'b0, 1'b0);
            end
            begin
                repeat (3) tick();
                rdy_mode = 2;
                tick();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
                    chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
                end
                rdy_mode = 0;
            end
        join
        drain();

        // Reset with two ops in flight: both are dropped.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b1, 1'b0);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("async_rst_sum", 32'(bus.sum), 32'(0));
        flushed += exp_q.size();
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bus.out_valid), 32'(0));
            tick();
        end
        send(8'h5A, 8'h25, 1'b1, 1'b0);
        drain();

        // Randomized traffic with random consumer backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) tick();
            send(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        rdy_mode = 0;
        tick();
        drain();

        chk("result_count", 32'(popped), 32'(pushed - flushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
